// File: rtl/mcp3201_pkg.sv
// Shared constants and FSM state type for the MCP3201 SPI reader.
package mcp3201_pkg;

  // Sample width of the MCP3201 (12-bit SAR ADC).
  localparam int MCP3201_RESOLUTION = 12;

  // SCLK rising edge that carries the null bit; data follows on the next edges.
  localparam int NULL_BIT_EDGE = 3;

  // Total SCLK pulses per frame: two sample-period clocks, the null bit, 12 data bits.
  localparam int FRAME_CLOCKS = 15;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } mcp3201_state_e;

endpackage

// File: rtl/mcp3201_spi_if.sv
// Bus bundle between the MCP3201 reader and its surroundings: conversion
// request, ADC serial lines and the sample/status outputs.
interface mcp3201_spi_if #(
  parameter int WIDTH = 12
);

  logic             start_i;
  logic             miso_i;
  logic             sclk_o;
  logic             cs_n_o;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             busy_o;
  logic             error_o;

  // Reader side: drives the SPI lines and the result outputs.
  modport master (
    input  start_i,
    input  miso_i,
    output sclk_o,
    output cs_n_o,
    output data_o,
    output valid_o,
    output busy_o,
    output error_o
  );

  // Requester / ADC side: issues conversions, drives DOUT, consumes results.
  modport slave (
    output start_i,
    output miso_i,
    input  sclk_o,
    input  cs_n_o,
    input  data_o,
    input  valid_o,
    input  busy_o,
    input  error_o
  );

endinterface

// File: rtl/mcp3201_spi_clk_div.sv
// Half-period tick generator for the SPI clock. While enabled it counts
// CLK_DIV clk_i cycles and flags the last one; disabling it clears the count
// so every enable window starts on a fresh half-period.
module spi_clk_div #(
  parameter int CLK_DIV = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == DIV_LAST);
  assign tick_o = en_i & w_last;

  // Half-period counter: restarts on the last count or whenever disabled.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cnt <= DIV_ZERO;
    end else if (!en_i || w_last) begin
      r_cnt <= DIV_ZERO;
    end else begin
      r_cnt <= r_cnt + DIV_ONE;
    end
  end

endmodule

// File: rtl/mcp3201_spi.sv
// MCP3201 frame reader. One accepted start produces one chip-select window:
// a CLK_DIV setup phase, 15 SCLK pulses (low phase first), then a chip-select
// high gap of CS_HIGH_CYCLES before another start is accepted. DOUT is
// sampled on each SCLK rise; rise 3 is the null bit, rises 4..15 are B11..B0.
module mcp3201_spi
  import mcp3201_pkg::*;
#(
  parameter int MCP3201_RESOLUTION = mcp3201_pkg::MCP3201_RESOLUTION,
  parameter int CLK_DIV            = 16,
  parameter int CS_HIGH_CYCLES     = 32
) (
  input  logic           clk_i,
  input  logic           reset_i,
  mcp3201_spi_if.master  bus
);

  localparam int RES = MCP3201_RESOLUTION;

  // Rising-edge counter holds 0..FRAME_CLOCKS, gap counter 0..CS_HIGH_CYCLES-1.
  localparam int EDGE_W = $clog2(FRAME_CLOCKS + 1);
  localparam int GAP_W  = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;

  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(FRAME_CLOCKS);
  localparam logic [EDGE_W-1:0] EDGE_NULL = EDGE_W'(NULL_BIT_EDGE);
  localparam logic [EDGE_W-1:0] EDGE_ZERO = EDGE_W'(0);
  localparam logic [EDGE_W-1:0] EDGE_ONE  = EDGE_W'(1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(CS_HIGH_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_ZERO  = GAP_W'(0);
  localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
  localparam logic [RES-1:0]    DATA_ZERO = RES'(0);

  // Registered state and outputs.
  mcp3201_state_e    r_state;
  logic              r_sclk;
  logic              r_cs_n;
  logic              r_valid;
  logic              r_busy;
  logic              r_error;
  logic [RES-1:0]    r_data;
  logic [RES-1:0]    r_shift;
  logic              r_null;
  logic [EDGE_W-1:0] r_edge_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;

  // Next-state values computed by the sequencer.
  mcp3201_state_e    w_state;
  logic              w_sclk;
  logic              w_cs_n;
  logic              w_valid;
  logic              w_busy;
  logic              w_error;
  logic [RES-1:0]    w_data;
  logic [RES-1:0]    w_shift;
  logic              w_null;
  logic [EDGE_W-1:0] w_edge_cnt;
  logic [GAP_W-1:0]  w_gap_cnt;

  logic              w_div_en;
  logic              w_tick;
  logic [EDGE_W-1:0] w_edge_inc;

  // The divider only runs during the chip-select-low part of the frame, so
  // it is cleared in IDLE/GAP and the setup phase starts on a full count.
  assign w_div_en   = (r_state == ST_SETUP) || (r_state == ST_SHIFT);
  assign w_edge_inc = r_edge_cnt + EDGE_ONE;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (w_div_en),
    .tick_o  (w_tick)
  );

  // Sequencer: next state, SPI lines, capture and result outputs.
  always_comb begin
    w_state    = r_state;
    w_sclk     = r_sclk;
    w_cs_n     = r_cs_n;
    w_valid    = 1'b0;
    w_busy     = r_busy;
    w_error    = r_error;
    w_data     = r_data;
    w_shift    = r_shift;
    w_null     = r_null;
    w_edge_cnt = r_edge_cnt;
    w_gap_cnt  = r_gap_cnt;

    case (r_state)
      ST_IDLE: begin
        if (bus.start_i) begin
          w_state    = ST_SETUP;
          w_cs_n     = 1'b0;
          w_busy     = 1'b1;
          w_sclk     = 1'b0;
          w_edge_cnt = EDGE_ZERO;
          w_gap_cnt  = GAP_ZERO;
          w_shift    = DATA_ZERO;
          w_null     = 1'b0;
        end else begin
          w_state = ST_IDLE;
        end
      end

      ST_SETUP: begin
        if (w_tick) begin
          w_state = ST_SHIFT;
        end else begin
          w_state = ST_SETUP;
        end
      end

      ST_SHIFT: begin
        if (w_tick && !r_sclk) begin
          // End of a low phase: raise SCLK and sample DOUT in the same cycle.
          w_sclk     = 1'b1;
          w_edge_cnt = w_edge_inc;
          if (w_edge_inc == EDGE_NULL) begin
            w_null = bus.miso_i;
          end else if (w_edge_inc > EDGE_NULL) begin
            w_shift = {r_shift[RES-2:0], bus.miso_i};
          end else begin
            w_shift = r_shift;
          end
        end else if (w_tick && r_sclk) begin
          if (r_edge_cnt == EDGE_LAST) begin
            // Last high phase done: close the frame and publish the sample.
            w_sclk    = 1'b0;
            w_cs_n    = 1'b1;
            w_data    = r_shift;
            w_error   = r_null;
            w_valid   = 1'b1;
            w_gap_cnt = GAP_ZERO;
            w_state   = ST_GAP;
          end else begin
            w_sclk = 1'b0;
          end
        end else begin
          w_state = ST_SHIFT;
        end
      end

      ST_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state   = ST_IDLE;
          w_busy    = 1'b0;
          w_gap_cnt = GAP_ZERO;
        end else begin
          w_gap_cnt = r_gap_cnt + GAP_ONE;
        end
      end

      default: begin
        w_state    = ST_IDLE;
        w_sclk     = 1'b0;
        w_cs_n     = 1'b1;
        w_busy     = 1'b0;
        w_edge_cnt = EDGE_ZERO;
        w_gap_cnt  = GAP_ZERO;
      end
    endcase
  end

  // State and output registers; reset wins over any start request.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= ST_IDLE;
      r_sclk     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_error    <= 1'b0;
      r_data     <= DATA_ZERO;
      r_shift    <= DATA_ZERO;
      r_null     <= 1'b0;
      r_edge_cnt <= EDGE_ZERO;
      r_gap_cnt  <= GAP_ZERO;
    end else begin
      r_state    <= w_state;
      r_sclk     <= w_sclk;
      r_cs_n     <= w_cs_n;
      r_valid    <= w_valid;
      r_busy     <= w_busy;
      r_error    <= w_error;
      r_data     <= w_data;
      r_shift    <= w_shift;
      r_null     <= w_null;
      r_edge_cnt <= w_edge_cnt;
      r_gap_cnt  <= w_gap_cnt;
    end
  end

  // SPI lines and results come straight from flops.
  assign bus.sclk_o  = r_sclk;
  assign bus.cs_n_o  = r_cs_n;
  assign bus.data_o  = r_data;
  assign bus.valid_o = r_valid;
  assign bus.busy_o  = r_busy;
  assign bus.error_o = r_error;

endmodule

// File: doc/mcp3201_spi.md
MCP3201_SPI -- requirements
Module: mcp3201_spi

Interface
REQ-001 SHALL have parameter MCP3201_RESOLUTION, default 12, ADC sample width in bits.
REQ-002 SHALL have parameter CLK_DIV, default 16, clk_i cycles per SCLK half-period (legal range >= 2).
REQ-003 SHALL have parameter CS_HIGH_CYCLES, default 32, minimum clk_i cycles cs_n_o stays high between frames (legal range >= 1).
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port start_i, input, 1 bit: conversion request, level-sampled.
REQ-007 SHALL have port miso_i, input, 1 bit: MCP3201 DOUT.
REQ-008 SHALL have port sclk_o, output, 1 bit: SPI clock, idle low.
REQ-009 SHALL have port cs_n_o, output, 1 bit: ADC chip select, active low.
REQ-010 SHALL have port data_o, output, MCP3201_RESOLUTION bits: last unsigned sample, drives the downstream angle_adc_i.
REQ-011 SHALL have port valid_o, output, 1 bit: one-cycle strobe marking new data_o, drives the downstream enable_i.
REQ-012 SHALL have port busy_o, output, 1 bit: high from the start accept until return to IDLE.
REQ-013 SHALL have port error_o, output, 1 bit: null bit of the last frame was not 0.

Function
REQ-014 SHALL implement FSM IDLE -> SETUP -> SHIFT -> GAP -> IDLE.
REQ-015 In IDLE with start_i=1, SHALL move to SETUP; cs_n_o=0 and busy_o=1 from the next cycle (cycle 1).
REQ-016 SETUP SHALL last CLK_DIV cycles with sclk_o=0, then move to SHIFT.
REQ-017 SHIFT SHALL emit exactly 15 SCLK pulses, each CLK_DIV cycles low followed by CLK_DIV cycles high; SHIFT starts with the low phase.
REQ-018 SHALL sample miso_i in the clk_i cycle where sclk_o goes 0->1.
REQ-019 Sampling, by rising edge: edges 1-2 ignored; edge 3 is the null bit; edges 4..15 are B11..B0, MSB first, shifted into an internal register.
REQ-020 After the high phase of edge 15, in a single cycle, SHALL:
- set sclk_o=0 and cs_n_o=1
- load data_o from the shift register
- set error_o to the captured null bit
- pulse valid_o for one cycle
- enter GAP
REQ-021 With H=CLK_DIV, valid_o SHALL rise at cycle 1+31H after the start-accept cycle 0 (125 for H=4).
REQ-022 GAP SHALL hold cs_n_o=1 and busy_o=1 for CS_HIGH_CYCLES cycles, then enter IDLE with busy_o=0.
REQ-023 start_i SHALL be ignored outside IDLE; no queuing.
REQ-024 start_i held high SHALL produce back-to-back frames, each separated by >= CS_HIGH_CYCLES cycles of cs_n_o=1.
REQ-025 data_o and error_o SHALL hold their values between valid_o strobes.
REQ-026 sclk_o and cs_n_o SHALL be driven directly from registers, glitch-free.
REQ-027 Divider and bit counters SHALL be sized by $clog2 of their maximum counts, and SHALL not wrap mid-frame.

Reset
REQ-028 reset_i=1 at any rising edge, including mid-frame, SHALL force next cycle: state IDLE, sclk_o=0, cs_n_o=1, valid_o=0, busy_o=0, error_o=0, data_o=0, all counters 0.
REQ-029 A frame aborted by reset SHALL never produce valid_o.
REQ-030 start_i asserted together with reset_i SHALL be ignored.

Structure
REQ-031 Package mcp3201_pkg SHALL hold: MCP3201_RESOLUTION, FRAME_CLOCKS=15, NULL_BIT_EDGE=3, and the FSM state enum.
REQ-032 A single sub-module spi_clk_div SHALL generate the half-period tick from CLK_DIV; everything else stays inline.

Verification (CLK_DIV=4, CS_HIGH_CYCLES=8; MCP3201 behavioural model driving DOUT on SCLK falling edges)
REQ-033 Model value 12'hABC, start_i pulsed at cycle 0 -> cs_n_o low at cycle 1, exactly 15 sclk_o rising edges, valid_o high only at cycle 125, data_o=12'hABC, error_o=0.
REQ-034 Model values 12'h000, then 12'hFFF, then 12'h800 -> data_o matches each, and a downstream degrees stage fed from data_o/valid_o receives one enable per frame.
REQ-035 Model forces null bit=1 with value 12'h123 -> data_o=12'h123, error_o=1; next clean frame -> error_o=0.
REQ-036 start_i re-pulsed during SHIFT and during GAP -> no extra frame, single valid_o; start_i held high -> successive cs_n_o low windows separated by >= 8 cycles.
REQ-037 reset_i asserted at cycle 60 mid-SHIFT -> cycle 61: cs_n_o=1, sclk_o=0, busy_o=0, data_o=0; no valid_o; next start yields a correct frame.
